// File: rtl/fir_mac_sequencer.sv
// Sequencer for a 7-tap symmetric FIR sharing one multiply-accumulate unit.
// Accepts samples, runs one tap per cycle and holds each result for a valid/ready consumer.
module fir_mac_sequencer #(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] inp,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic          cfg_drop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] outp,
  output logic [AW-1:0] out_full,
  output logic          busy,
  output logic [1:0]    fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid of the same channel.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [AW-1:0] SAT = AW'({DW{1'b1}});

  state_t          state, state_next;
  logic [DW-1:0]   q [0:6];
  logic [DW-1:0]   c1, c2, c3;
  logic [AW-1:0]   acc;
  logic [2:0]      tap;
  logic            take;
  logic [DW-1:0]   tap_sample, tap_coef;
  logic [2*DW-1:0] prod;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MAC;
      MAC:     if (tap == 3'd6) state_next = OUT;
      OUT:     if (out_ready) state_next = in_valid ? MAC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outer taps are fixed at 1; inner pairs share one register each.
  always_comb begin
    tap_sample = '0;
    tap_coef   = '0;
    case (tap)
      3'd0: begin tap_sample = q[0]; tap_coef = DW'(1); end
      3'd1: begin tap_sample = q[1]; tap_coef = c1;     end
      3'd2: begin tap_sample = q[2]; tap_coef = c2;     end
      3'd3: begin tap_sample = q[3]; tap_coef = c3;     end
      3'd4: begin tap_sample = q[4]; tap_coef = c2;     end
      3'd5: begin tap_sample = q[5]; tap_coef = c1;     end
      3'd6: begin tap_sample = q[6]; tap_coef = DW'(1); end
      default: begin tap_sample = '0; tap_coef = '0;    end
    endcase
  end

  assign prod      = tap_sample * tap_coef;
  assign in_ready  = (state == IDLE) || ((state == OUT) && out_ready);
  assign take      = in_valid && in_ready;
  assign out_valid = (state == OUT);
  assign busy      = (state == MAC);
  assign out_full  = acc;
  assign outp      = (acc > SAT) ? {DW{1'b1}} : acc[DW-1:0];
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      tap      <= '0;
      c1       <= DW'(2);
      c2       <= DW'(3);
      c3       <= DW'(4);
      cfg_drop <= 1'b0;
      for (int k = 0; k < 7; k++) q[k] <= '0;
    end else begin
      state    <= state_next;
      cfg_drop <= cfg_we && (cfg_addr != 2'd0) && (state != IDLE);
      if (cfg_we && (state == IDLE)) begin
        case (cfg_addr)
          2'd1:    c1 <= cfg_data;
          2'd2:    c2 <= cfg_data;
          2'd3:    c3 <= cfg_data;
          default: ;
        endcase
      end
      if (take) begin
        q[0] <= inp;
        for (int k = 1; k < 7; k++) q[k] <= q[k-1];
        acc <= '0;
        tap <= '0;
      end else if (state == MAC) begin
        acc <= acc + AW'(prod);
        tap <= tap + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: fixed vector tables, corner sequences
// and randomized traffic against a sum-of-products reference model.
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cfg_we, cfg_drop, out_valid, out_ready, busy;
  logic [7:0]  inp, cfg_data, outp;
  logic [1:0]  cfg_addr, fsm_state;
  logic [15:0] out_full;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.DW(8), .AW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_drop(cfg_drop),
    .out_valid(out_valid), .out_ready(out_ready), .outp(outp), .out_full(out_full),
    .busy(busy), .fsm_state(fsm_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: newest sample first, response = sum of sample * tap weight.
  int hist[7];
  int coef[4];

  task automatic model_reset();
    for (int i = 0; i < 7; i++) hist[i] = 0;
    coef[0] = 1; coef[1] = 2; coef[2] = 3; coef[3] = 4;
  endtask

  task automatic model_push(input int s, output int full, output int sat);
    int sum, m;
    for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    sum = 0;
    for (int t = 0; t < 7; t++) begin
      m = (t <= 3) ? t : 6 - t;
      sum += hist[t] * ((m == 0) ? 1 : coef[m]);
    end
    full = sum % 65536;
    sat  = (full > 255) ? 255 : full;
  endtask

  logic [7:0]  got_o;
  logic [15:0] got_f;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_drop_idle", cfg_drop, 0);
    coef[a] = d;
  endtask

  // Called on the negedge right after the handshake edge (lat0 = 1 there).
  task automatic wait_out(input int lat0, input bit chk_busy);
    int lat, bc;
    lat = lat0; bc = 0;
    while (!out_valid && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 8);
    if (chk_busy) check("busy_cycles", bc, 7);
    got_o = outp;
    got_f = out_full;
  endtask

  task automatic start(input logic [7:0] s, input bit poke);
    int lat0;
    @(negedge clk);
    in_valid = 1'b1; inp = s; out_ready = 1'b0;
    #1 check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; inp = 8'($urandom);
    lat0 = 1;
    if (poke) begin
      cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 8'd9;
      @(negedge clk);
      cfg_we = 1'b0;
      check("cfg_drop_pulse", cfg_drop, 1);
      @(negedge clk);
      check("cfg_drop_once", cfg_drop, 0);
      lat0 = 3;
    end
    wait_out(lat0, !poke);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_one(input logic [7:0] s, input int stall, input bit poke);
    start(s, poke);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_outp", outp, got_o);
      check("stall_in_ready", in_ready, 0);
    end
    release_out();
  endtask

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  eo;
    logic [15:0] ef;
  } vec_t;

  vec_t tbl[16];
  int   c3zero[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ef, eo, seen;
    logic [7:0] s;

    tbl[0]  = '{8'd1,  8'd1,   16'd1};
    tbl[1]  = '{8'd0,  8'd2,   16'd2};
    tbl[2]  = '{8'd0,  8'd3,   16'd3};
    tbl[3]  = '{8'd0,  8'd4,   16'd4};
    tbl[4]  = '{8'd0,  8'd3,   16'd3};
    tbl[5]  = '{8'd0,  8'd2,   16'd2};
    tbl[6]  = '{8'd0,  8'd1,   16'd1};
    tbl[7]  = '{8'd0,  8'd0,   16'd0};
    tbl[8]  = '{8'd10, 8'd10,  16'd10};
    tbl[9]  = '{8'd10, 8'd30,  16'd30};
    tbl[10] = '{8'd10, 8'd60,  16'd60};
    tbl[11] = '{8'd10, 8'd100, 16'd100};
    tbl[12] = '{8'd10, 8'd130, 16'd130};
    tbl[13] = '{8'd10, 8'd150, 16'd150};
    tbl[14] = '{8'd10, 8'd160, 16'd160};
    tbl[15] = '{8'd10, 8'd160, 16'd160};
    c3zero  = '{1, 2, 3, 0, 3, 2, 1};

    rst = 1'b1; in_valid = 1'b0; inp = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_drop", cfg_drop, 0);
    check("rst_out_full", out_full, 0);
    check("rst_state", fsm_state, 0);

    // Impulse then step, default coefficients.
    for (int i = 0; i < 16; i++) begin
      run_one(tbl[i].s, 0, 1'b0);
      check("tbl_outp", got_o, tbl[i].eo);
      check("tbl_out_full", got_f, tbl[i].ef);
    end

    // Saturation.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      model_push(255, ef, eo);
      run_one(8'd255, 0, 1'b0);
      check("sat_outp", got_o, eo);
      check("sat_out_full", got_f, ef);
    end
    check("sat_full_4080", got_f, 4080);
    check("sat_outp_255", got_o, 255);

    // Backpressure for 5 cycles, then a back-to-back accept.
    model_push(77, ef, eo);
    start(8'd77, 1'b0);
    check("bp_outp", got_o, eo);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_outp_stable", outp, got_o);
      check("bp_full_stable", out_full, got_f);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b1; inp = 8'd5;
    #1 check("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_out_valid", out_valid, 0);
    model_push(5, ef, eo);
    wait_out(1, 1'b1);
    check("b2b_outp", got_o, eo);
    check("b2b_out_full", got_f, ef);
    release_out();

    // c3 = 0 in IDLE; a write attempted mid-MAC must be dropped.
    do_reset();
    cfg_write(2'd3, 8'd0);
    for (int i = 0; i < 7; i++) begin
      model_push((i == 0) ? 1 : 0, ef, eo);
      run_one((i == 0) ? 8'd1 : 8'd0, 0, i == 3);
      check("c3zero_outp", got_o, c3zero[i]);
    end

    // Reset at tap 3.
    do_reset();
    for (int i = 0; i < 3; i++) run_one(8'($urandom_range(50, 255)), 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; inp = 8'd200;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mid_rst_state", fsm_state, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("mid_rst_no_output", seen, 0);
    for (int i = 0; i < 7; i++) begin
      model_push((i == 0) ? 1 : 0, ef, eo);
      run_one((i == 0) ? 8'd1 : 8'd0, 0, 1'b0);
      check("post_rst_impulse", got_o, eo);
    end
    check("post_rst_peak_seen", coef[3], 4);

    // Randomized traffic with random coefficients and stalls.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write(2'($urandom_range(1, 3)), 8'($urandom));
      s = 8'($urandom);
      model_push(s, ef, eo);
      run_one(s, $urandom_range(0, 3), 1'b0);
      check("rnd_outp", got_o, eo);
      check("rnd_out_full", got_f, ef);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed controller for the 7-tap symmetric FIR. It accepts samples over a valid/ready handshake and keeps the 7-deep sample delay line. It sequences a single shared multiply-accumulate unit across the taps, one tap per cycle, and presents each filtered result over a valid/ready output handshake. It sits between the sample source and the downstream consumer, replacing the fully parallel multiplier/adder tree when area matters more than throughput.

## Interface
- `DW`, 8: sample and coefficient width (unsigned).
- `AW`, 16: accumulator width; must be ≥ 2·DW.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `inp`  in  DW  input sample.
- `cfg_we`  in  1  coefficient write strobe.
- `cfg_addr`  in  2  coefficient select: 1 = c1/c5, 2 = c2/c4, 3 = c3; 0 is ignored.
- `cfg_data`  in  DW  coefficient value.
- `cfg_drop`  out  1  one-cycle pulse: a `cfg_we` was rejected.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `outp`  out  DW  result, saturated to DW bits.
- `out_full`  out  AW  full-precision accumulator value.
- `busy`  out  1  high in the MAC state.

## Operation
- **Delay line q[0..6]** (DW each) shifts only on an input handshake (`in_valid & in_ready`):
  - q[0] ← `inp`; q[k] ← q[k-1].
- **Coefficients** are symmetric:
  - c0 = c6 = 1, fixed.
  - c1 = c5, c2 = c4, c3 are registers.
  - Reset values: c1 = 2, c2 = 3, c3 = 4.
- **Config writes:**
  - Applied only in IDLE.
  - `cfg_we` in MAC or OUT is dropped, and `cfg_drop` pulses on the following cycle.
  - `cfg_addr` = 0 is ignored without a drop pulse.
- **FSM: IDLE, MAC, OUT.**
  - IDLE: `in_ready` = 1. On handshake: shift the line, acc ← 0, tap ← 0, go to MAC.
  - MAC: each cycle, acc ← acc + q[tap]·c[tap], tap ← tap + 1. After tap 6, go to OUT.
  - OUT: `out_valid` = 1; `outp` and `out_full` are held stable.
    - On `out_ready` with no `in_valid`: go to IDLE.
    - On `out_ready` with `in_valid` (back-to-back): accept the sample, shift, clear acc, go to MAC.
- **`in_ready`** = (state == IDLE) | (state == OUT & `out_ready`).
- **Arithmetic:**
  - Products are DW×DW unsigned, 2·DW bits, zero-extended to AW.
  - acc wraps modulo 2^AW; maximum 16·(2^DW−1) = 4080 fits for defaults.
  - `out_full` = acc.
  - `outp` = (acc > 2^DW−1) ? 2^DW−1 : acc[DW−1:0].
- **Reset** (any state, including mid-MAC or in OUT with `out_valid` high):
  - State → IDLE; q[*], acc and tap → 0; coefficients → reset values.
  - `out_valid`, `cfg_drop`, `busy` → 0; `in_ready` = 1 on the first cycle after reset.
  - An interrupted computation produces no output.
- Input data is don't-care when `in_valid` = 0. The line never shifts without a handshake.

## Timing
- Handshake at edge E:
  - Taps 0..6 are accumulated at edges E+1..E+7.
  - `out_valid` is high from after E+7.
  - Latency is 8 cycles, handshake to `out_valid`.
- With `out_ready` held high and `in_valid` always high, throughput is one sample per 8 cycles.
- `busy` is high for exactly 7 cycles per sample.
- Output stays stable while `out_valid & !out_ready`, for any length of stall.
- The coefficients used for a sample are those held at its input handshake; they cannot change mid-MAC.

## Test plan
- **Impulse:** default coefficients; inputs 1,0,0,0,0,0,0,0 → `outp` sequence 1,2,3,4,3,2,1,0, each 8 cycles after its handshake when `out_ready` = 1.
- **Step:** constant 10 → `outp` 10,30,60,100,130,150,160, then 160 steady; `out_full` equals `outp`.
- **Saturation:** constant 255 → after 7 samples `out_full` = 4080, `outp` = 255.
- **Backpressure:** `out_ready` low for 5 cycles in OUT → `out_valid` held, `outp` stable, `in_ready` = 0. On `out_ready` = 1 with `in_valid` = 1, the next sample is accepted in that same cycle.
- **Config:**
  - Write c3 = 0 in IDLE → impulse response becomes 1,2,3,0,3,2,1.
  - `cfg_we` during MAC → `cfg_drop` pulses once and the coefficient is unchanged.
- **Reset mid-MAC:** assert `rst` at tap 3 → no `out_valid`, state IDLE, and a subsequent impulse yields 1,2,3,4,3,2,1 (the delay line was cleared).
